// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcodes, FSM states
// and a conditional two's-complement negate helper.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Helper works on the widest value the unit handles (the 2*WIDTH product).
  localparam int unsigned MD_MAXW = 64;

  function automatic logic [MD_MAXW-1:0] md_neg_if(input logic [MD_MAXW-1:0] x,
                                                    input logic neg);
    return neg ? (~x + MD_MAXW'(1)) : x;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring
// divide, one bit per cycle, sign fix-up on a final FIX cycle.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mdstartE,
  input  logic [2:0]       mdopE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             stallE,
  input  logic             flushE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE,
  output logic             mdrunE
);

  localparam int unsigned W2 = 2 * WIDTH;

  md_state_e        state;
  logic [CNTW-1:0]  cnt;
  logic             is_div, neg_q, neg_r, divzero;
  logic [WIDTH-1:0] a_raw, op_a, op_b, rem;
  logic [W2-1:0]    acc;

  logic             go, is_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign go        = mdstartE & ~stallE & ~flushE & (state == MD_IDLE);
  assign is_signed = (mdopE == MD_MULT) || (mdopE == MD_DIV);
  assign a_abs     = WIDTH'(md_neg_if(MD_MAXW'(srcaE), is_signed & srcaE[WIDTH-1]));
  assign b_abs     = WIDTH'(md_neg_if(MD_MAXW'(srcbE), is_signed & srcbE[WIDTH-1]));

  // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
  assign mul_sum   = {1'b0, acc[W2-1:WIDTH]} + (op_b[0] ? {1'b0, op_a} : '0);

  // Divide: W+1-bit partial remainder, quotient bits shift into op_a from the right.
  assign div_shift = {rem, op_a[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, op_b};
  assign div_diff  = WIDTH'(div_shift - {1'b0, op_b});

  assign prod_fix  = W2'(md_neg_if(MD_MAXW'(acc), neg_q));
  assign quot_fix  = WIDTH'(md_neg_if(MD_MAXW'(op_a), neg_q));
  assign rem_fix   = WIDTH'(md_neg_if(MD_MAXW'(rem), neg_r));

  assign mdrunE    = (state != MD_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      divzero <= 1'b0;
      a_raw   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      rem     <= '0;
      acc     <= '0;
      hiE     <= '0;
      loE     <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (go) begin
            case (mdopE)
              MD_MTHI: hiE <= srcaE;
              MD_MTLO: loE <= srcaE;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                is_div  <= (mdopE == MD_DIV) || (mdopE == MD_DIVU);
                neg_q   <= is_signed & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                neg_r   <= is_signed & srcaE[WIDTH-1];
                divzero <= ((mdopE == MD_DIV) || (mdopE == MD_DIVU)) && (srcbE == '0);
                a_raw   <= srcaE;
                op_a    <= a_abs;
                op_b    <= b_abs;
                rem     <= '0;
                acc     <= '0;
                cnt     <= '0;
                state   <= MD_BUSY;
              end
              default: ;
            endcase
          end
        end
        MD_BUSY: begin
          if (flushE) begin
            state <= MD_IDLE;
          end else begin
            if (is_div) begin
              rem  <= div_ge ? div_diff : div_shift[WIDTH-1:0];
              op_a <= {op_a[WIDTH-2:0], div_ge};
            end else begin
              acc  <= {mul_sum, acc[WIDTH-1:1]};
              op_b <= op_b >> 1;
            end
            cnt <= cnt + CNTW'(1);
            if (cnt == CNTW'(WIDTH - 1)) state <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (!flushE) begin
            if (!is_div) begin
              {hiE, loE} <= prod_fix;
            end else if (divzero) begin
              loE <= '1;
              hiE <= a_raw;
            end else begin
              loE <= quot_fix;
              hiE <= rem_fix;
            end
          end
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the Execute stage. Owns the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and runs multi-cycle arithmetic.
- Drives mdrunE to the hazard unit, which stalls HI/LO accesses in Decode while the unit is busy.
- Results become visible on hiE/loE when the operation retires.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- mdstartE  input  1  E-stage instruction is a mult/div/mthi/mtlo
- mdopE  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- srcaE  input  WIDTH  rs operand (multiplicand/dividend/move source)
- srcbE  input  WIDTH  rt operand (multiplier/divisor)
- stallE  input  1  E stage held; start not accepted
- flushE  input  1  E stage squashed; start not accepted, in-flight operation aborted
- hiE  output  WIDTH  HI register
- loE  output  WIDTH  LO register
- mdrunE  output  1  operation in flight

Behaviour:
- Reset (synchronous, active-high) forces:
  - state = IDLE, hiE = 0, loE = 0, mdrunE = 0, counter = 0.
  - Reset mid-operation discards all partial state.
- Acceptance: `go = mdstartE & ~stallE & ~flushE & (state==IDLE)`.
  - When not IDLE, mdstartE is ignored. No queueing, no error flag.
- States:
  - IDLE:
    - go with MTHI → hiE <= srcaE next edge; state stays IDLE; mdrunE stays 0.
    - go with MTLO → loE <= srcaE next edge; state stays IDLE; mdrunE stays 0.
    - go with MULT/MULTU/DIV/DIVU:
      - latch |srcaE| and |srcbE| (raw values for unsigned ops);
      - latch neg_q = sign(a)^sign(b) and neg_r = sign(a), both signed ops only;
      - latch divzero = (srcbE==0) for DIV/DIVU;
      - clear the accumulator; counter = 0; state → BUSY.
    - Reserved opcodes: no effect.
  - BUSY: one iteration per edge.
    - Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
    - Divide: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
    - counter increments each cycle. After the edge where counter reaches WIDTH-1 (WIDTH iterations), state → FIX.
  - FIX: on its single edge write HI/LO, then state → IDLE.
    - Multiply: {hiE,loE} = neg_q ? -product : product (2*WIDTH-bit two's complement).
    - Divide: loE = neg_q ? -quot : quot; hiE = neg_r ? -rem : rem.
    - Divide by zero, both DIV and DIVU: loE = all ones, hiE = srcaE as latched (raw, not abs); no sign fix.
- mdrunE = (state != IDLE), decoded directly from the state register.
  - High for exactly WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
  - Falls in the same cycle the new hiE/loE become visible.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: loE = 0x80000000, hiE = 0. Unsigned magnitude arithmetic on WIDTH bits yields this naturally; no special path.
- flushE while BUSY or FIX: state → IDLE at that edge; hiE/loE keep their previous values; mdrunE = 0 next cycle.
- stallE while BUSY/FIX: no effect; iterations continue.
- go and flushE in the same cycle: flush wins, nothing is accepted.
- hiE/loE change only at an MTHI/MTLO edge, a FIX edge, or reset.

Decomposition:
- Shared package md_pkg holds:
  - opcode localparams MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO;
  - state encoding MD_IDLE/MD_BUSY/MD_FIX (2 bits).
- The E-stage decoder imports md_pkg for the same opcodes.
- No sub-module needed. The abs/negate helper is a small function in the package.

Test Plan:
- Reset then idle:
  - hiE = loE = 0, mdrunE = 0.
  - mdstartE = 0 for 10 cycles → no change.
- MULT srca = 0xFFFFFFFD (-3), srcb = 5:
  - mdrunE high for 33 cycles;
  - then hiE = 0xFFFFFFFF, loE = 0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hiE = 0xFFFFFFFE, loE = 0x00000001 after 33 busy cycles.
- DIV 0xFFFFFFF9 (-7) / 2:
  - first → loE = 0xFFFFFFFD, hiE = 0xFFFFFFFF;
  - then DIVU 7 / 0 → loE = 0xFFFFFFFF, hiE = 0x00000007.
- Start MULT 6×7, assert flushE at busy cycle 10:
  - mdrunE = 0 next cycle, hiE/loE unchanged;
  - MTLO 0x1234 issued during busy (before the flush) is ignored; reissued after → loE = 0x1234 next edge, mdrunE stays 0.
- Start DIVU 100/7, assert reset at busy cycle 20 → next cycle state IDLE, hiE = loE = 0, mdrunE = 0. Also check that mdstartE with stallE = 1 is not accepted.
